// File: rtl/result_display.sv
// Four-digit multiplexed common-anode hex display for the 16-bit result bus.
// Captures result once per frame, with a ghosting guard, leading-zero blanking and a change marker on dp.
module result_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] result,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [1:0]       dig;
    logic [15:0]      shadow;
    logic             changed;

    logic             tick_c;
    logic             capture_c;
    logic             lzb_c;
    logic             on_c;
    logic [3:0]       nib_c;
    logic [6:0]       code_c;

    // Slot timing, digit selection and blanking decisions
    always_comb begin
        tick_c    = (div == DIV_W'(SCAN_DIV - 1));
        capture_c = tick_c && (dig == 2'd3);
        nib_c     = 4'h0;
        lzb_c     = 1'b0;
        case (dig)
            2'd0: nib_c = shadow[3:0];
            2'd1: begin
                nib_c = shadow[7:4];
                lzb_c = lz_en && (shadow[15:4] == 12'h000);
            end
            2'd2: begin
                nib_c = shadow[11:8];
                lzb_c = lz_en && (shadow[15:8] == 8'h00);
            end
            default: begin
                nib_c = shadow[15:12];
                lzb_c = lz_en && (shadow[15:12] == 4'h0);
            end
        endcase
        on_c = (div >= DIV_W'(BLANK)) && !lzb_c;
    end

    // Hex glyphs, active-high gfedcba
    always_comb begin
        code_c = 7'h00;
        case (nib_c)
            4'h0: code_c = 7'h3F;
            4'h1: code_c = 7'h06;
            4'h2: code_c = 7'h5B;
            4'h3: code_c = 7'h4F;
            4'h4: code_c = 7'h66;
            4'h5: code_c = 7'h6D;
            4'h6: code_c = 7'h7D;
            4'h7: code_c = 7'h07;
            4'h8: code_c = 7'h7F;
            4'h9: code_c = 7'h6F;
            4'hA: code_c = 7'h77;
            4'hB: code_c = 7'h7C;
            4'hC: code_c = 7'h39;
            4'hD: code_c = 7'h5E;
            4'hE: code_c = 7'h79;
            default: code_c = 7'h71;
        endcase
    end

    // Scan counters, frame capture and the registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            dig        <= 2'd0;
            shadow     <= 16'h0000;
            changed    <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            div        <= tick_c ? '0 : div + DIV_W'(1);
            if (tick_c) begin
                dig <= dig + 2'd1;
            end
            frame_tick <= capture_c;
            if (capture_c) begin
                shadow  <= result;
                changed <= (result != shadow);
            end
            an  <= on_c ? ~(4'b0001 << dig) : 4'b1111;
            seg <= on_c ? ~code_c : 7'h7F;
            dp  <= ~(on_c && (dig == 2'd0) && changed);
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display with SCAN_DIV=8, BLANK=2: per-cycle scoreboard against a frame-position
// model, plus a table of hand-derived frame patterns and hand-written reset / mid-frame sequences.
module tb_result_display;

    localparam int unsigned SD  = 8;
    localparam int unsigned BL  = 2;
    localparam int unsigned FRM = 4 * SD;

    logic        clk;
    logic        rst_n;
    logic [15:0] result;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    result_display #(.SCAN_DIV(SD), .BLANK(BL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .result(result),
        .lz_en(lz_en),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } out_t;

    typedef struct {
        logic [15:0] result;
        logic        lz;
        logic [15:0] an4;   // slot3..slot0
        logic [27:0] seg4;  // slot3..slot0
        logic        dp0;
    } vec_t;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    out_t        sb [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          mpos = 0;
    logic [15:0] m_shadow = 16'h0;
    logic        m_changed = 1'b0;
    vec_t        vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: predict outputs from model state, advance model, compare at the falling edge
    task automatic step();
        out_t        e;
        out_t        got;
        int          slot;
        int          off;
        logic        lzb;
        logic        on;
        logic [3:0]  nib;
        slot  = mpos / SD;
        off   = mpos % SD;
        nib   = 4'(m_shadow >> (4 * slot));
        lzb   = lz_en && (slot >= 1) && ((m_shadow >> (4 * slot)) == 16'h0);
        on    = (off >= BL) && !lzb;
        e.an  = on ? 4'(~(4'b0001 << slot)) : 4'b1111;
        e.seg = on ? ~glyph[nib] : 7'h7F;
        e.dp  = !(on && slot == 0 && m_changed);
        e.ft  = (mpos == FRM - 1);
        sb.push_back(e);
        if (mpos == FRM - 1) begin
            m_changed = (result != m_shadow);
            m_shadow  = result;
        end
        mpos = (mpos + 1) % FRM;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = '{an: an, seg: seg, dp: dp, ft: frame_tick};
            chk("cycle_outputs", 32'(got), 32'(sb.pop_front()));
        end
    endtask

    task automatic goto(input int p);
        for (int i = 0; i < FRM + 2 && mpos != p; i++) step();
        chk("goto_reached", 32'(mpos), 32'(p));
    endtask

    task automatic model_reset();
        mpos      = 0;
        m_shadow  = 16'h0;
        m_changed = 1'b0;
        sb.delete();
    endtask

    // At most one anode low on every cycle
    always @(negedge clk) begin
        n_vec++;
        if ($countones(~an) > 1) begin
            n_bad++;
            $display("FAIL onehot_an: got %b expected at most one zero at %0t", an, $time);
        end
    end

    initial begin
        int ft_count;
        vt[0] = '{16'h0000, 1'b0, 16'b0111_1011_1101_1110, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
        vt[1] = '{16'h1A3F, 1'b0, 16'b0111_1011_1101_1110, {7'h79, 7'h08, 7'h30, 7'h0E}, 1'b0};
        vt[2] = '{16'h0005, 1'b1, 16'b1111_1111_1111_1110, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0};
        vt[3] = '{16'h0005, 1'b0, 16'b0111_1011_1101_1110, {7'h40, 7'h40, 7'h40, 7'h12}, 1'b1};
        vt[4] = '{16'h00A0, 1'b1, 16'b1111_1111_1101_1110, {7'h7F, 7'h7F, 7'h08, 7'h40}, 1'b0};
        vt[5] = '{16'hF000, 1'b1, 16'b0111_1011_1101_1110, {7'h0E, 7'h40, 7'h40, 7'h40}, 1'b0};

        rst_n  = 1'b0;
        result = 16'h0000;
        lz_en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_an", 32'(an), 32'hF);
            chk("reset_seg", 32'(seg), 32'h7F);
            chk("reset_dp", 32'(dp), 32'h1);
            chk("reset_ft", 32'(frame_tick), 32'h0);
        end
        rst_n = 1'b1;
        model_reset();

        // First frame after reset: dark/lit cadence showing 0000
        for (int i = 0; i < FRM; i++) begin
            step();
            if (i % SD >= BL) begin
                chk("boot_an", 32'(an), 32'(4'(~(4'b0001 << (i / SD)))));
                chk("boot_seg", 32'(seg), 32'h40);
            end else begin
                chk("boot_dark", 32'(an), 32'hF);
            end
        end

        // Table of captured values and their full-frame appearance
        for (int v = 0; v < 6; v++) begin
            result = vt[v].result;
            lz_en  = vt[v].lz;
            step();
            goto(0);
            for (int s = 0; s < 4; s++) begin
                goto(s * SD + 5);
                step();
                chk($sformatf("vec%0d_an_slot%0d", v, s), 32'(an), 32'(vt[v].an4[4*s +: 4]));
                chk($sformatf("vec%0d_seg_slot%0d", v, s), 32'(seg), 32'(vt[v].seg4[7*s +: 7]));
                if (s == 0) chk($sformatf("vec%0d_dp", v), 32'(dp), 32'(vt[v].dp0));
            end
        end

        // Mid-frame change is held off until the next capture
        lz_en  = 1'b0;
        result = 16'h1111;
        step();
        goto(0);
        step();
        goto(0);
        goto(10);
        result = 16'h2222;
        goto(13);
        step();
        chk("midframe_hold_an", 32'(an), 32'hD);
        chk("midframe_hold_seg", 32'(seg), 32'h79);
        goto(0);
        ft_count = 0;
        for (int i = 0; i < 2 * FRM; i++) begin
            step();
            if (frame_tick) ft_count++;
            if (i == 5) begin
                chk("new_val_seg", 32'(seg), 32'h24);
                chk("new_val_dp", 32'(dp), 32'h0);
            end
            if (i == FRM + 5) chk("stable_val_dp", 32'(dp), 32'h1);
        end
        chk("frame_tick_count", 32'(ft_count), 32'd2);

        // Asynchronous reset in the middle of slot 2
        goto(19);
        #1 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_dp", 32'(dp), 32'h1);
        #2 rst_n = 1'b1;
        model_reset();
        result = 16'h1234;
        for (int i = 0; i < 3; i++) step();
        chk("recover_an", 32'(an), 32'hE);
        chk("recover_seg_cleared", 32'(seg), 32'h40);
        goto(0);
        goto(SD + 4);
        step();
        chk("recover_new_seg", 32'(seg), 32'h30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
